csr_excp_seq: RTL and testbench

- Multi-cycle sequencer that owns the single CSR-file write port and shares it between ordinary mm2 CSRWR/CSRXCHG writes and hardware exception/ERTN updates.
- Sits at the mm2 stage, downstream of the mm2 exception/CSR-control decode.
- On an exception or ERTN it stalls mm2, performs the architectural CSR updates one write per cycle, then pulses a pipeline flush with the redirect PC.

---
 rtl/csr_excp_seq.sv | 239 +++++++++++++++++++++++
 tb/tb_csr_excp_seq.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_excp_seq.sv
// csr_excp_seq: owns the CSR write port at mm2 and shares it between
// software CSRWR/CSRXCHG writes and exception/ERTN update sequences.
//
// Ports:
//   clk, reset            core clock, async active-high reset
//   mm2_*                 mm2 instruction info and software CSR request
//   *_rdata               current CRMD/PRMD/ERA/EENTRY values
//   mm2_ready             mm2 may retire (sequencer idle)
//   csr_we/num/wdata/wmask  single CSR write port (mask bit 1 = written)
//   flush, redirect_pc    one-cycle flush with fetch target
//   busy                  sequencer is running a sequence
//
// Build option: define CSR_SEQ_BADV_EN to add the BADV write step.
module csr_excp_seq #(
  parameter logic [13:0] CSR_CRMD  = 14'h000,
  parameter logic [13:0] CSR_PRMD  = 14'h001,
  parameter logic [13:0] CSR_ESTAT = 14'h005,
  parameter logic [13:0] CSR_ERA   = 14'h006,
  parameter logic [13:0] CSR_BADV  = 14'h007
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mm2_valid,
  input  logic        mm2_excp,
  input  logic [5:0]  mm2_ecode,
  input  logic [8:0]  mm2_esubcode,
  input  logic        mm2_ertn,
  input  logic [31:0] mm2_pc,
  input  logic        mm2_badv_valid,
  input  logic [31:0] mm2_badv,
  input  logic        mm2_csr_we,
  input  logic [13:0] mm2_csr_num,
  input  logic [31:0] mm2_csr_wdata,
  input  logic [31:0] mm2_csr_wmask,
  input  logic [31:0] crmd_rdata,
  input  logic [31:0] prmd_rdata,
  input  logic [31:0] era_rdata,
  input  logic [31:0] eentry_rdata,
  output logic        mm2_ready,
  output logic        csr_we,
  output logic [13:0] csr_num,
  output logic [31:0] csr_wdata,
  output logic [31:0] csr_wmask,
  output logic        flush,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  localparam logic [31:0] MASK_PLV_IE = 32'h0000_0007;
  localparam logic [31:0] MASK_ECODE  = 32'h7FFF_0000;
  localparam logic [31:0] MASK_ALL    = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    W_PRMD  = 3'd1,
    W_ERA   = 3'd2,
    W_ESTAT = 3'd3,
`ifdef CSR_SEQ_BADV_EN
    W_BADV  = 3'd4,
`endif
    W_CRMD  = 3'd5,
    E_CRMD  = 3'd6,
    REDIR   = 3'd7
  } state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [13:0] num_q, num_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] wmask_q, wmask_d;
  logic        flush_q, flush_d;
  logic [31:0] rpc_q, rpc_d;
  logic [5:0]  ecode_q, ecode_d;
  logic [8:0]  esub_q, esub_d;
  logic [31:0] pc_q, pc_d;
`ifdef CSR_SEQ_BADV_EN
  logic [31:0] badv_q, badv_d;
  logic        badv_v_q, badv_v_d;
`else
  logic        unused_badv;
  assign unused_badv = ^{mm2_badv, mm2_badv_valid};
`endif

  logic unused_bits;
  assign unused_bits = ^{crmd_rdata[31:3], prmd_rdata[31:3]};

  // Outputs for state N are computed on the edge that enters N,
  // so every CSR write and the flush come straight from flops.
  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    num_d   = '0;
    wdata_d = '0;
    wmask_d = '0;
    flush_d = 1'b0;
    rpc_d   = '0;
    ecode_d = ecode_q;
    esub_d  = esub_q;
    pc_d    = pc_q;
`ifdef CSR_SEQ_BADV_EN
    badv_d   = badv_q;
    badv_v_d = badv_v_q;
`endif
    case (state_q)
      IDLE: begin
        if (mm2_valid && mm2_excp) begin
          state_d = W_PRMD;
          ecode_d = mm2_ecode;
          esub_d  = mm2_esubcode;
          pc_d    = mm2_pc;
`ifdef CSR_SEQ_BADV_EN
          badv_d   = mm2_badv;
          badv_v_d = mm2_badv_valid;
`endif
          we_d    = 1'b1;
          num_d   = CSR_PRMD;
          wdata_d = {29'd0, crmd_rdata[2:0]};
          wmask_d = MASK_PLV_IE;
        end else if (mm2_valid && mm2_ertn) begin
          state_d = E_CRMD;
          we_d    = 1'b1;
          num_d   = CSR_CRMD;
          wdata_d = {29'd0, prmd_rdata[2:0]};
          wmask_d = MASK_PLV_IE;
        end
      end
      W_PRMD: begin
        state_d = W_ERA;
        we_d    = 1'b1;
        num_d   = CSR_ERA;
        wdata_d = pc_q;
        wmask_d = MASK_ALL;
      end
      W_ERA: begin
        state_d = W_ESTAT;
        we_d    = 1'b1;
        num_d   = CSR_ESTAT;
        wdata_d = {1'b0, esub_q, ecode_q, 16'h0};
        wmask_d = MASK_ECODE;
      end
      W_ESTAT: begin
`ifdef CSR_SEQ_BADV_EN
        if (badv_v_q) begin
          state_d = W_BADV;
          we_d    = 1'b1;
          num_d   = CSR_BADV;
          wdata_d = badv_q;
          wmask_d = MASK_ALL;
        end else begin
          state_d = W_CRMD;
          we_d    = 1'b1;
          num_d   = CSR_CRMD;
          wmask_d = MASK_PLV_IE;
        end
`else
        state_d = W_CRMD;
        we_d    = 1'b1;
        num_d   = CSR_CRMD;
        wmask_d = MASK_PLV_IE;
`endif
      end
`ifdef CSR_SEQ_BADV_EN
      W_BADV: begin
        state_d = W_CRMD;
        we_d    = 1'b1;
        num_d   = CSR_CRMD;
        wmask_d = MASK_PLV_IE;
      end
`endif
      W_CRMD: begin
        state_d = REDIR;
        flush_d = 1'b1;
        rpc_d   = eentry_rdata;
      end
      E_CRMD: begin
        state_d = REDIR;
        flush_d = 1'b1;
        rpc_d   = era_rdata;
      end
      REDIR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      num_q   <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      flush_q <= 1'b0;
      rpc_q   <= '0;
      ecode_q <= '0;
      esub_q  <= '0;
      pc_q    <= '0;
`ifdef CSR_SEQ_BADV_EN
      badv_q   <= '0;
      badv_v_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      num_q   <= num_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      flush_q <= flush_d;
      rpc_q   <= rpc_d;
      ecode_q <= ecode_d;
      esub_q  <= esub_d;
      pc_q    <= pc_d;
`ifdef CSR_SEQ_BADV_EN
      badv_q   <= badv_d;
      badv_v_q <= badv_v_d;
`endif
    end
  end

  logic idle;
  logic pass_we;

  assign idle    = (state_q == IDLE);
  // A software write is dropped when the same instruction traps or is ERTN.
  assign pass_we = mm2_valid & mm2_csr_we & ~mm2_excp & ~mm2_ertn;

  assign mm2_ready   = idle;
  assign busy        = ~idle;
  assign csr_we      = idle ? pass_we       : we_q;
  assign csr_num     = idle ? mm2_csr_num   : num_q;
  assign csr_wdata   = idle ? mm2_csr_wdata : wdata_q;
  assign csr_wmask   = idle ? mm2_csr_wmask : wmask_q;
  assign flush       = flush_q;
  assign redirect_pc = rpc_q;

endmodule

// File: tb/tb_csr_excp_seq.sv
// tb_csr_excp_seq: scoreboard bench for csr_excp_seq.
// Expected CSR writes/flushes are queued by stimulus, popped by a monitor.
module tb_csr_excp_seq;

  localparam logic [13:0] N_CRMD  = 14'h000;
  localparam logic [13:0] N_PRMD  = 14'h001;
  localparam logic [13:0] N_ESTAT = 14'h005;
  localparam logic [13:0] N_ERA   = 14'h006;
  localparam logic [13:0] N_BADV  = 14'h007;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mm2_valid, mm2_excp, mm2_ertn;
  logic [5:0]  mm2_ecode;
  logic [8:0]  mm2_esubcode;
  logic [31:0] mm2_pc, mm2_badv;
  logic        mm2_badv_valid, mm2_csr_we;
  logic [13:0] mm2_csr_num;
  logic [31:0] mm2_csr_wdata, mm2_csr_wmask;
  logic [31:0] crmd_rdata, prmd_rdata, era_rdata, eentry_rdata;
  logic        mm2_ready, csr_we, flush, busy;
  logic [13:0] csr_num;
  logic [31:0] csr_wdata, csr_wmask, redirect_pc;

  csr_excp_seq dut (
    .clk(clk), .reset(rst),
    .mm2_valid(mm2_valid), .mm2_excp(mm2_excp),
    .mm2_ecode(mm2_ecode), .mm2_esubcode(mm2_esubcode),
    .mm2_ertn(mm2_ertn), .mm2_pc(mm2_pc),
    .mm2_badv_valid(mm2_badv_valid), .mm2_badv(mm2_badv),
    .mm2_csr_we(mm2_csr_we), .mm2_csr_num(mm2_csr_num),
    .mm2_csr_wdata(mm2_csr_wdata), .mm2_csr_wmask(mm2_csr_wmask),
    .crmd_rdata(crmd_rdata), .prmd_rdata(prmd_rdata),
    .era_rdata(era_rdata), .eentry_rdata(eentry_rdata),
    .mm2_ready(mm2_ready), .csr_we(csr_we), .csr_num(csr_num),
    .csr_wdata(csr_wdata), .csr_wmask(csr_wmask),
    .flush(flush), .redirect_pc(redirect_pc), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          fl;
    logic [13:0] num;
    logic [31:0] data;
    logic [31:0] mask;
    logic [31:0] cm;
    int          at;
  } exp_t;

  exp_t exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (cyc %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic push(input bit fl, input logic [13:0] num,
                      input logic [31:0] d, input logic [31:0] m,
                      input logic [31:0] cm, input int at);
    exp_t e;
    e.fl = fl; e.num = num; e.data = d;
    e.mask = m; e.cm = cm; e.at = at;
    exp_q.push_back(e);
  endtask

  // Monitor: every write strobe or flush must match the head of the queue.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (csr_we || flush)) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected output: we=%b flush=%b num=%h data=%h cyc=%0d",
                 csr_we, flush, csr_num, csr_wdata, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("kind_flush", {31'd0, flush}, {31'd0, e.fl});
        if (e.fl) begin
          chk("redirect_pc", redirect_pc, e.data);
        end else begin
          chk("csr_num", {18'd0, csr_num}, {18'd0, e.num});
          chk("csr_wdata", csr_wdata & e.cm, e.data & e.cm);
          chk("csr_wmask", csr_wmask, e.mask);
        end
        chk("cycle", cyc, e.at);
      end
    end
  end

  task automatic idle_inputs();
    mm2_valid = 0; mm2_excp = 0; mm2_ertn = 0;
    mm2_ecode = '0; mm2_esubcode = '0; mm2_pc = '0;
    mm2_badv_valid = 0; mm2_badv = '0; mm2_csr_we = 0;
    mm2_csr_num = '0; mm2_csr_wdata = '0; mm2_csr_wmask = '0;
  endtask

  // kind: 0 CSRWR, 1 exception, 2 ERTN, 3 exception+ERTN+CSR write.
  // Called and returns at 1 time unit after a rising edge.
  task automatic txn(input int kind, input logic [31:0] pc,
                     input logic [5:0] ec, input logic [8:0] es,
                     input logic bv, input logic [31:0] badv,
                     input logic [31:0] crmd, input logic [31:0] prmd,
                     input logic [31:0] era, input logic [31:0] eentry,
                     input logic [13:0] num, input logic [31:0] wd,
                     input logic [31:0] wm);
    int p;
    int k;
    bit is_exc;
    crmd_rdata = crmd; prmd_rdata = prmd;
    era_rdata = era; eentry_rdata = eentry;
    is_exc = (kind == 1 || kind == 3);
    mm2_valid = 1;
    mm2_excp = is_exc;
    mm2_ertn = (kind == 2 || kind == 3);
    mm2_csr_we = (kind == 0 || kind == 3) ? 1'b1 : 1'($urandom_range(0, 1));
    mm2_pc = pc; mm2_ecode = ec; mm2_esubcode = es;
    mm2_badv_valid = bv; mm2_badv = badv;
    mm2_csr_num = num; mm2_csr_wdata = wd; mm2_csr_wmask = wm;
    p = cyc;
    k = 0;
    chk("ready_idle", {31'd0, mm2_ready}, 32'd1);
    chk("busy_idle", {31'd0, busy}, 32'd0);
    if (kind == 0) begin
      push(0, num, wd, wm, 32'hFFFF_FFFF, p);
      @(posedge clk); #1;
      idle_inputs();
    end else begin
      if (is_exc) begin
        push(0, N_PRMD, crmd & 32'h7, 32'h7, 32'h7, p + 1 + k); k++;
        push(0, N_ERA, pc, 32'hFFFF_FFFF, 32'hFFFF_FFFF, p + 1 + k); k++;
        push(0, N_ESTAT, {1'b0, es, ec, 16'h0}, 32'h7FFF_0000,
             32'h7FFF_0000, p + 1 + k); k++;
`ifdef CSR_SEQ_BADV_EN
        if (bv) begin
          push(0, N_BADV, badv, 32'hFFFF_FFFF, 32'hFFFF_FFFF, p + 1 + k);
          k++;
        end
`endif
        push(0, N_CRMD, 32'h0, 32'h7, 32'h7, p + 1 + k); k++;
        push(1, '0, eentry, '0, '0, p + 1 + k); k++;
      end else begin
        push(0, N_CRMD, prmd & 32'h7, 32'h7, 32'h7, p + 1 + k); k++;
        push(1, '0, era, '0, '0, p + 1 + k); k++;
      end
      @(posedge clk); #1;
      // While busy, mm2 carries unrelated requests that must be ignored.
      mm2_valid = 1;
      mm2_excp = 1'($urandom_range(0, 1));
      mm2_ertn = 1'($urandom_range(0, 1));
      mm2_csr_we = 1;
      mm2_csr_num = 14'($urandom);
      mm2_csr_wdata = $urandom;
      mm2_csr_wmask = $urandom;
      for (int i = 0; i < k; i++) begin
        if (i == k - 1) idle_inputs();
        chk("ready_busy", {31'd0, mm2_ready}, 32'd0);
        chk("busy_busy", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
      end
    end
    chk("drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    idle_inputs();
    crmd_rdata = '0; prmd_rdata = '0;
    era_rdata = '0; eentry_rdata = '0;
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we", {31'd0, csr_we}, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_num", {18'd0, csr_num}, 32'd0);
    chk("rst_wdata", csr_wdata, 32'd0);
    chk("rst_wmask", csr_wmask, 32'd0);
    chk("rst_rpc", redirect_pc, 32'd0);
    rst = 0;
    @(posedge clk); #1;

    // Plain CSRWR pass-through
    txn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 14'h00C, 32'h1C00_8000, 32'hFFFF_FFFF);
    // SYS exception, no BADV
    txn(1, 32'h1C00_0100, 6'h0B, 9'h0, 0, 0, 32'h7, 32'h0, 32'h0,
        32'h1C00_8000, 14'h0, 32'h0, 32'h0);
    // ALE with BADV
    txn(1, 32'h1C00_0200, 6'h09, 9'h0, 1, 32'h3, 32'h3, 32'h0, 32'h0,
        32'h1C00_8000, 14'h0, 32'h0, 32'h0);
    // ERTN
    txn(2, 32'h1C00_0300, 0, 0, 0, 0, 32'h0, 32'h5, 32'h1C00_0104,
        32'h0, 14'h0, 32'h0, 32'h0);
    // Exception and ERTN together with a software write
    txn(3, 32'h1C00_0400, 6'h0C, 9'h1, 0, 0, 32'h4, 32'h2, 32'h1C00_0104,
        32'h1C00_9000, 14'h00C, 32'hDEAD_BEEF, 32'hFFFF_FFFF);

    // Reset in the middle of an exception sequence
    crmd_rdata = 32'h7; eentry_rdata = 32'h1C00_8000;
    mm2_valid = 1; mm2_excp = 1; mm2_ecode = 6'h0B; mm2_pc = 32'h1C00_0500;
    push(0, N_PRMD, 32'h7, 32'h7, 32'h7, cyc + 1);
    push(0, N_ERA, 32'h1C00_0500, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc + 2);
    @(posedge clk); #1;
    idle_inputs();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1;
    #1;
    chk("midrst_drained", exp_q.size(), 32'd0);
    exp_q.delete();
    chk("midrst_we", {31'd0, csr_we}, 32'd0);
    chk("midrst_flush", {31'd0, flush}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_ready", {31'd0, mm2_ready}, 32'd1);
    chk("midrst_wdata", csr_wdata, 32'd0);
    chk("midrst_rpc", redirect_pc, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    for (int i = 0; i < 6; i++) begin
      chk("postrst_flush", {31'd0, flush}, 32'd0);
      chk("postrst_we", {31'd0, csr_we}, 32'd0);
      @(posedge clk); #1;
    end
    txn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 14'h040, 32'h1234_5678, 32'h0000_FFFF);

    // Randomized traffic
    for (int t = 0; t < 200; t++) begin
      int idle_n;
      txn($urandom_range(0, 3), $urandom, 6'($urandom), 9'($urandom),
          1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
          $urandom, $urandom, 14'($urandom), $urandom, $urandom);
      idle_n = $urandom_range(0, 2);
      repeat (idle_n) begin
        @(posedge clk); #1;
      end
    end

    repeat (4) @(posedge clk);
    #1;
    chk("final_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
